monopulse_ratio: RTL and testbench

MONOPULSE_RATIO -- requirements
Module: monopulse_ratio

---
 rtl/monopulse_pkg.sv | 22 ++
 rtl/monopulse_divider.sv | 64 ++++++
 rtl/monopulse_ratio.sv | 135 +++++++++++++
 tb/tb_monopulse_ratio.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/monopulse_pkg.sv
// Shared types and saturation constants for the monopulse ratio block.
package monopulse_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ABS  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Saturation helpers work on a wide word so any DATA_SIZE up to 63 fits.
    localparam int unsigned SAT_W = 64;

    function automatic logic [SAT_W-1:0] sat_max_unsigned(input int unsigned width);
        return (SAT_W'(1) << width) - SAT_W'(1);
    endfunction

    function automatic logic [SAT_W-1:0] sat_max_signed(input int unsigned width);
        return (SAT_W'(1) << (width - 1)) - SAT_W'(1);
    endfunction

endpackage

// File: rtl/monopulse_divider.sv
// Restoring unsigned divider, one quotient bit per clock; o_quotient_c is the
// quotient after the current step, complete when o_done_c is high.
module monopulse_divider #(
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned FRAC_BITS = 16,
    localparam int unsigned Q_W = DATA_SIZE + FRAC_BITS
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [Q_W-1:0]       i_dividend,
    input  logic [DATA_SIZE-1:0] i_divisor,
    output logic                 o_busy,
    output logic                 o_done_c,
    output logic [Q_W-1:0]       o_quotient_c
);
    localparam int unsigned CNT_W = $clog2(Q_W + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(Q_W - 1);

    logic [DATA_SIZE-1:0] r_rem;
    logic [DATA_SIZE-1:0] r_div;
    logic [Q_W-1:0]       r_dq;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_busy;

    logic [DATA_SIZE:0]   w_shift;
    logic [DATA_SIZE-1:0] w_diff;
    logic                 w_ge;

    // r_dq shifts dividend bits out of the top while quotient bits enter at the bottom.
    always_comb begin
        w_shift = {r_rem, r_dq[Q_W-1]};
        w_ge    = (w_shift >= {1'b0, r_div});
        w_diff  = DATA_SIZE'(w_shift - {1'b0, r_div});
    end

    assign o_quotient_c = {r_dq[Q_W-2:0], w_ge};
    assign o_done_c     = r_busy && (r_cnt == LAST);
    assign o_busy       = r_busy;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_rem  <= '0;
            r_div  <= '0;
            r_dq   <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_rem  <= '0;
            r_div  <= i_divisor;
            r_dq   <= i_dividend;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_rem <= w_ge ? w_diff : w_shift[DATA_SIZE-1:0];
            r_dq  <= o_quotient_c;
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == LAST) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/monopulse_ratio.sv
// Monopulse ratio |error| / |reference| in Q(DATA_SIZE-FRAC_BITS).FRAC_BITS.
// Define MONOPULSE_SIGN_EN for a signed result carrying sign(error) ^ sign(reference).
module monopulse_ratio
    import monopulse_pkg::*;
#(
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned FRAC_BITS = 16
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [DATA_SIZE-1:0] i_reference,
    input  logic [DATA_SIZE-1:0] i_error,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [DATA_SIZE-1:0] o_relation,
    output logic                 o_div_zero
);
    localparam int unsigned Q_W = DATA_SIZE + FRAC_BITS;
`ifdef MONOPULSE_SIGN_EN
    localparam logic [SAT_W-1:0] SAT_MAX = sat_max_signed(DATA_SIZE);
`else
    localparam logic [SAT_W-1:0] SAT_MAX = sat_max_unsigned(DATA_SIZE);
`endif
    localparam logic [DATA_SIZE-1:0] REL_MAX = DATA_SIZE'(SAT_MAX);

    state_t               r_state;
    logic                 r_ready;
    logic                 r_valid;
    logic [DATA_SIZE-1:0] r_relation;
    logic                 r_div_zero;
    logic [DATA_SIZE-1:0] r_ref;
    logic [DATA_SIZE-1:0] r_err;
`ifdef MONOPULSE_SIGN_EN
    logic                 r_sign;
`endif

    logic [DATA_SIZE-1:0] w_mag_ref;
    logic [DATA_SIZE-1:0] w_mag_err;
    logic                 w_start;
    logic                 w_div_busy;
    logic                 w_div_done_c;
    logic [Q_W-1:0]       w_quo_c;
    logic [DATA_SIZE-1:0] w_mag_sat;
    logic [DATA_SIZE-1:0] w_result;

    // Magnitudes as unsigned words: the most negative input maps to 2^(DATA_SIZE-1).
    always_comb begin
        w_mag_ref = r_ref[DATA_SIZE-1] ? (~r_ref + DATA_SIZE'(1)) : r_ref;
        w_mag_err = r_err[DATA_SIZE-1] ? (~r_err + DATA_SIZE'(1)) : r_err;
        w_start   = (r_state == ABS) && (w_mag_ref != '0);
        w_mag_sat = (SAT_W'(w_quo_c) > SAT_MAX) ? REL_MAX : w_quo_c[DATA_SIZE-1:0];
`ifdef MONOPULSE_SIGN_EN
        w_result  = r_sign ? (~w_mag_sat + DATA_SIZE'(1)) : w_mag_sat;
`else
        w_result  = w_mag_sat;
`endif
    end

    monopulse_divider #(
        .DATA_SIZE (DATA_SIZE),
        .FRAC_BITS (FRAC_BITS)
    ) u_divider (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_start      (w_start),
        .i_dividend   ({w_mag_err, {FRAC_BITS{1'b0}}}),
        .i_divisor    (w_mag_ref),
        .o_busy       (w_div_busy),
        .o_done_c     (w_div_done_c),
        .o_quotient_c (w_quo_c)
    );

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= IDLE;
            r_ready    <= 1'b1;
            r_valid    <= 1'b0;
            r_relation <= '0;
            r_div_zero <= 1'b0;
            r_ref      <= '0;
            r_err      <= '0;
`ifdef MONOPULSE_SIGN_EN
            r_sign     <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_valid) begin
                        r_ref   <= i_reference;
                        r_err   <= i_error;
                        r_ready <= 1'b0;
                        r_state <= ABS;
                    end
                end
                ABS: begin
`ifdef MONOPULSE_SIGN_EN
                    r_sign <= r_err[DATA_SIZE-1] ^ r_ref[DATA_SIZE-1];
`endif
                    if (w_mag_ref == '0) begin
                        r_relation <= REL_MAX;
                        r_div_zero <= 1'b1;
                        r_valid    <= 1'b1;
                        r_state    <= DONE;
                    end else begin
                        r_state <= DIV;
                    end
                end
                DIV: begin
                    if (w_div_busy && w_div_done_c) begin
                        r_relation <= w_result;
                        r_div_zero <= 1'b0;
                        r_valid    <= 1'b1;
                        r_state    <= DONE;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_ready    = r_ready;
    assign o_valid    = r_valid;
    assign o_relation = r_relation;
    assign o_div_zero = r_div_zero;

endmodule

// File: tb/tb_monopulse_ratio.sv
// Directed-vector bench for monopulse_ratio (DATA_SIZE=32, FRAC_BITS=16).
module tb_monopulse_ratio;

`ifdef MONOPULSE_SIGN_EN
    localparam bit SIGNED = 1'b1;
`else
    localparam bit SIGNED = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_reference;
    logic [31:0] i_error;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_relation;
    logic        o_div_zero;

    int checks;
    int failures;

    typedef struct {
        logic [31:0] ref_v;
        logic [31:0] err_v;
        logic [31:0] rel;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    monopulse_ratio #(
        .DATA_SIZE (32),
        .FRAC_BITS (16)
    ) dut (
        .i_clock     (clk),
        .i_reset     (rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_reference (i_reference),
        .i_error     (i_error),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_relation  (o_relation),
        .o_div_zero  (o_div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    // Launch one sample and count edges after the accepting edge until o_valid.
    task automatic do_op(input logic [31:0] r, input logic [31:0] e, output int lat);
        int k;
        k = 0;
        while (!o_ready && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        i_valid     = 1'b1;
        i_reference = r;
        i_error     = e;
        @(posedge clk); #1;
        i_reference = ~r;
        i_error     = e ^ 32'h5A5A_5A5A;
        lat = 0;
        while (!o_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        i_valid = 1'b0;
    endtask

    task automatic finish_op(input string name);
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
        check({name, "_valid_drop"}, 32'(o_valid), 32'd0);
        check({name, "_ready_rise"}, 32'(o_ready), 32'd1);
    endtask

    initial begin
        int lat;
        bit seen_valid;
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        i_valid     = 1'b0;
        i_ready     = 1'b0;
        i_reference = '0;
        i_error     = '0;

        vecs[0]  = '{32'd4,         32'd2,         32'h0000_8000, 1'b0, 49};
        vecs[1]  = '{32'hFFFF_FFFC, 32'd2,         SIGNED ? 32'hFFFF_8000 : 32'h0000_8000, 1'b0, 49};
        vecs[2]  = '{32'd0,         32'd5,         SIGNED ? 32'h7FFF_FFFF : 32'hFFFF_FFFF, 1'b1, 1};
        vecs[3]  = '{32'd1,         32'h7FFF_FFFF, SIGNED ? 32'h7FFF_FFFF : 32'hFFFF_FFFF, 1'b0, 49};
        vecs[4]  = '{32'h8000_0000, 32'h8000_0000, 32'h0001_0000, 1'b0, 49};
        vecs[5]  = '{32'd3,         32'd1,         32'h0000_5555, 1'b0, 49};
        vecs[6]  = '{32'd2,         32'hFFFF_FFFD, SIGNED ? 32'hFFFE_8000 : 32'h0001_8000, 1'b0, 49};
        vecs[7]  = '{32'd0,         32'd0,         SIGNED ? 32'h7FFF_FFFF : 32'hFFFF_FFFF, 1'b1, 1};
        vecs[8]  = '{32'd7,         32'd0,         32'h0000_0000, 1'b0, 49};
        vecs[9]  = '{32'h0001_0000, 32'd1,         32'h0000_0001, 1'b0, 49};
        vecs[10] = '{32'h7FFF_FFFF, 32'h8000_0000, SIGNED ? 32'hFFFF_0000 : 32'h0001_0000, 1'b0, 49};
        vecs[11] = '{32'hFFFF_FFFF, 32'h0000_8000, SIGNED ? 32'h8000_0001 : 32'h8000_0000, 1'b0, 49};

        #12;
        check("rst_valid",    32'(o_valid),    32'd0);
        check("rst_relation", o_relation,      32'd0);
        check("rst_div_zero", 32'(o_div_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_ready", 32'(o_ready), 32'd1);

        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i].ref_v, vecs[i].err_v, lat);
            check($sformatf("v%0d_relation", i), o_relation,      vecs[i].rel);
            check($sformatf("v%0d_div_zero", i), 32'(o_div_zero), 32'(vecs[i].dz));
            check($sformatf("v%0d_latency", i),  32'(lat),        32'(vecs[i].lat));
            finish_op($sformatf("v%0d", i));
        end

        // Result must hold while downstream stalls.
        do_op(32'd4, 32'd2, lat);
        check("stall_latency", 32'(lat), 32'd49);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check($sformatf("stall%0d_valid", c),    32'(o_valid),    32'd1);
            check($sformatf("stall%0d_relation", c), o_relation,      32'h0000_8000);
            check($sformatf("stall%0d_ready", c),    32'(o_ready),    32'd0);
        end
        finish_op("stall");

        // Reset in the middle of the divide abandons the operation.
        i_valid     = 1'b1;
        i_reference = 32'd4;
        i_error     = 32'd2;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (21) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid",    32'(o_valid),    32'd0);
        check("midrst_relation", o_relation,      32'd0);
        check("midrst_div_zero", 32'(o_div_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_ready", 32'(o_ready), 32'd1);
        seen_valid = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            if (o_valid) seen_valid = 1'b1;
        end
        check("midrst_no_result", 32'(seen_valid), 32'd0);

        do_op(32'd8, 32'd2, lat);
        check("post_rst_relation", o_relation,      32'h0000_4000);
        check("post_rst_div_zero", 32'(o_div_zero), 32'd0);
        check("post_rst_latency",  32'(lat),        32'd49);
        finish_op("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
